ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//   Shares one single-port synchronous word RAM (1-cycle read latency, single
//   full-word write enable) between two picoRV32-native-style requesters:
//   m0 = CPU, m1 = loader/debug master. Round-robin arbitration. Byte-strobe
//   writes are converted to read-modify-write sequences, since the RAM has no
//   byte enables.
// PARAMETERS
//   ADDR_W   8   RAM word-address width (8 -> 256 words, 9 -> 512 words)
// PORTS
//   clk         in   1       single clock, all state on posedge
//   resetn      in   1       asynchronous, active-low reset
//   m0_valid    in   1       m0 request; held until m0_ready
//   m0_ready    out  1       one-cycle completion pulse
//   m0_addr     in   32      byte address; bits [ADDR_W+1:2] are used
//   m0_wdata    in   32      write data
//   m0_wstrb    in   4       byte strobes; 0 = read
//   m0_rdata    out  32      read data, valid while m0_ready=1
//   m1_*        -    -       identical set for requester 1
//   mem_wen     out  1       RAM write enable
//   mem_addr    out  ADDR_W  RAM word address
//   mem_wdata   out  32      RAM write data
//   mem_rdata   in   32      RAM read data (registered inside the RAM)
//   grant       out  1       port currently or last served (0=m0, 1=m1)
//   busy        out  1       high in every state except IDLE
// BEHAVIOUR
//   - All outputs registered. Reset values: m*_ready=0, m*_rdata=0, mem_wen=0,
//     mem_addr=0, mem_wdata=0, grant=1 (so m0 wins the first tie), busy=0,
//     state=IDLE.
//   - FSM: IDLE, RD, DATA, WR, DONE.
//   - IDLE: if any valid, choose a port. If only one is valid, that port wins.
//     If both are valid, the port != grant wins. Latch addr/wdata/wstrb and
//     load mem_addr.
//     - wstrb==0 -> RD
//     - wstrb==4'hF -> WR, with mem_wdata=wdata and mem_wen=1
//     - any other wstrb -> RD
//   - RD: mem_addr stable; RAM samples it at the end of the cycle. Go to DATA.
//   - DATA: mem_rdata valid.
//     - Read: capture into the granted port's rdata, set its ready, go to DONE.
//     - Partial write: mem_wdata = per-byte merge (strobed bytes from wdata,
//       others from mem_rdata), mem_wen=1, go to WR.
//   - WR: mem_wen=1 for exactly this cycle. Set the granted port's ready;
//     go to DONE.
//   - DONE: the granted port's ready=1 for this cycle only; mem_wen=0; go to
//     IDLE. No new grant is taken in DONE, so the requester may drop valid.
//   - Latency, counted from the cycle valid is first seen in IDLE (cycle 0):
//     read -> ready in cycle 3; full write -> ready in cycle 2; partial
//     write -> ready in cycle 4.
//   - The non-granted port's ready and rdata hold. rdata changes only on reads.
//   - Address aliasing: addr bits above ADDR_W+1 and bits [1:0] are ignored.
//   - If valid is dropped mid-transaction, the access still completes to the
//     RAM and ready still pulses (protocol violation, but defined).
//   - Back-to-back requests from one port while the other is idle are all
//     served; minimum 1 IDLE cycle between transactions.
//   - resetn low at any time: immediate return to IDLE, mem_wen=0, and an
//     in-flight RMW is abandoned (RAM word either untouched or fully written,
//     never half-merged).
// TESTING
//   - m0 read of addr 0x10, RAM[4]=0xAABBCCDD -> m0_ready in cycle 3,
//     m0_rdata=0xAABBCCDD; m1_ready stays 0.
//   - m1 write addr 0x08, wstrb=F, wdata=0x12345678 -> mem_wen 1 cycle with
//     mem_addr=2; m1_ready in cycle 2; a following read returns 0x12345678.
//   - RAM[3]=0x11223344, m0 write addr 0x0C, wstrb=4'b0101, wdata=0xAABBCCDD
//     -> RAM[3]=0x11BB33DD; m0_ready in cycle 4.
//   - m0 and m1 valid together after reset -> m0 served first, m1 next;
//     repeat with both held -> grants alternate 0,1,0,1.
//   - Address wrap at ADDR_W=8: write addr 0x400 -> lands in RAM[0].
//   - Assert resetn low during WR of an RMW -> outputs at reset values within
//     the same cycle; FSM IDLE; the next request is served normally.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous word RAM.
// Partial byte-strobe writes become read-modify-write sequences.
module ram_port_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic [31:0]       m1_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              grant,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
  } req_t;

  state_t            state_q, state_d;
  req_t [1:0]        port_req;
  req_t              req_q, req_d;
  logic [1:0]        vld;
  logic              sel;
  logic              grant_q, grant_d;
  logic [1:0]        ready_q, ready_d;
  logic [1:0][31:0]  rdata_q, rdata_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       merged;
  logic              busy_q, busy_d;
  logic              unused_addr_bits;

  assign vld         = {m1_valid, m0_valid};
  assign port_req[0] = '{addr: m0_addr[ADDR_W+1:2], wdata: m0_wdata, wstrb: m0_wstrb};
  assign port_req[1] = '{addr: m1_addr[ADDR_W+1:2], wdata: m1_wdata, wstrb: m1_wstrb};
  // On a tie the port that was not served last wins.
  assign sel         = (&vld) ? ~grant_q : vld[1];

  assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                              m1_addr[31:ADDR_W+2], m1_addr[1:0]};

  for (genvar b = 0; b < 4; b++) begin : g_merge
    assign merged[8*b +: 8] = req_q.wstrb[b] ? req_q.wdata[8*b +: 8] : mem_rdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|vld) state_d = (port_req[sel].wstrb == 4'hF) ? WR : RD;
      RD:      state_d = DATA;
      DATA:    state_d = (req_q.wstrb == 4'h0) ? DONE : WR;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d       = req_q;
    grant_d     = grant_q;
    ready_d     = '0;
    rdata_d     = rdata_q;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: if (|vld) begin
        grant_d    = sel;
        req_d      = port_req[sel];
        mem_addr_d = port_req[sel].addr;
        if (port_req[sel].wstrb == 4'hF) begin
          mem_wdata_d = port_req[sel].wdata;
          mem_wen_d   = 1'b1;
        end
      end
      DATA: if (req_q.wstrb == 4'h0) begin
        rdata_d[grant_q] = mem_rdata;
        ready_d[grant_q] = 1'b1;
      end else begin
        mem_wdata_d = merged;
        mem_wen_d   = 1'b1;
      end
      WR:      ready_d[grant_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q       <= '0;
      grant_q     <= 1'b1;
      ready_q     <= '0;
      rdata_q     <= '0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      req_q       <= req_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign m0_ready  = ready_q[0];
  assign m1_ready  = ready_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule
